// File: rtl/set_pe_pkg.sv
// Shared types, default sizes, width helpers and the set-expression function for the point-coverage engine.
package set_pe_pkg;

  localparam int COORD_W_DEF  = 4;
  localparam int NUM_CIRC_DEF = 3;

  function automatic int diff_w(input int coord_w);
    return coord_w + 1;
  endfunction

  function automatic int sqr_w(input int coord_w);
    return 2 * coord_w;
  endfunction

  function automatic int d2_w(input int coord_w);
    return 2 * coord_w + 1;
  endfunction

  localparam int DIFF_W = diff_w(COORD_W_DEF);
  localparam int SQR_W  = sqr_w(COORD_W_DEF);
  localparam int D2_W   = d2_w(COORD_W_DEF);

  typedef struct packed {
    logic [COORD_W_DEF-1:0] cx;
    logic [COORD_W_DEF-1:0] cy;
    logic [COORD_W_DEF-1:0] r;
  } circle_t;

  // Bits outside sel are don't-care; an empty selection always hits.
  function automatic logic hit_eval(input logic [7:0] mask, input logic [7:0] val,
                                    input logic [7:0] sel);
    return ((mask ^ val) & sel) == 8'd0;
  endfunction

endpackage

// File: rtl/set_pe_lane.sv
// One circle's datapath: S1 signed diffs, S2 squares and r^2, S3 distance sum; compare is combinational off S3.
module set_pe_lane
  import set_pe_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               en,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] r,
  output logic               cov_p3
);

  localparam int DW  = diff_w(COORD_W);
  localparam int SW  = sqr_w(COORD_W);
  localparam int D2W = d2_w(COORD_W);

  logic signed [DW-1:0]   dx_p1_d, dx_p1_q, dy_p1_d, dy_p1_q;
  logic [COORD_W-1:0]     r_p1_d, r_p1_q;
  logic signed [SW-1:0]   dx_ext, dy_ext;
  logic [SW-1:0]          sqx_p2_d, sqx_p2_q, sqy_p2_d, sqy_p2_q;
  logic [SW-1:0]          rsq_p2_d, rsq_p2_q, rsq_p3_d, rsq_p3_q;
  logic [SW-1:0]          r_ext;
  logic [D2W-1:0]         d2_p3_d, d2_p3_q;

  always_comb begin
    // S1: coordinates are unsigned, so widen by one bit before subtracting
    dx_p1_d  = $signed({1'b0, in_x}) - $signed({1'b0, cx});
    dy_p1_d  = $signed({1'b0, in_y}) - $signed({1'b0, cy});
    r_p1_d   = r;
    // S2: sign-extend to the square width so the product is exact
    dx_ext   = SW'(dx_p1_q);
    dy_ext   = SW'(dy_p1_q);
    sqx_p2_d = $unsigned(dx_ext * dx_ext);
    sqy_p2_d = $unsigned(dy_ext * dy_ext);
    r_ext    = SW'(r_p1_q);
    rsq_p2_d = r_ext * r_ext;
    // S3
    d2_p3_d  = {1'b0, sqx_p2_q} + {1'b0, sqy_p2_q};
    rsq_p3_d = rsq_p2_q;
    cov_p3   = d2_p3_q <= {1'b0, rsq_p3_q};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      dx_p1_q  <= dx_p1_d;
      dy_p1_q  <= dy_p1_d;
      r_p1_q   <= r_p1_d;
      sqx_p2_q <= sqx_p2_d;
      sqy_p2_q <= sqy_p2_d;
      rsq_p2_q <= rsq_p2_d;
      d2_p3_q  <= d2_p3_d;
      rsq_p3_q <= rsq_p3_d;
    end
  end

endmodule

// File: rtl/set_pe_pipe.sv
// Point-coverage engine top: NUM_CIRC lanes, valid chain, circle config, set-expression hit.
// Optional saturating hit counter enabled by defining SET_PE_HITCNT_EN.
module set_pe_pipe
  import set_pe_pkg::*;
#(
  parameter int NUM_CIRC = NUM_CIRC_DEF,
  parameter int COORD_W  = COORD_W_DEF,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = (NUM_CIRC > 1) ? $clog2(NUM_CIRC) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [COORD_W-1:0]  cfg_cx,
  input  logic [COORD_W-1:0]  cfg_cy,
  input  logic [COORD_W-1:0]  cfg_r,
  output logic                cfg_busy,
  input  logic [NUM_CIRC-1:0] match_mask,
  input  logic [NUM_CIRC-1:0] match_val,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COORD_W-1:0]  in_x,
  input  logic [COORD_W-1:0]  in_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_CIRC-1:0] out_mask,
`ifdef SET_PE_HITCNT_EN
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    hit_cnt,
`endif
  output logic                out_hit
);

  if (NUM_CIRC < 1 || NUM_CIRC > 8 || CNT_W < 1) begin : g_param_chk
    $error("set_pe_pipe: NUM_CIRC must be 1..8 and CNT_W at least 1");
  end

  logic                en;
  logic                vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;
  logic                out_valid_d, out_valid_q;
  logic [NUM_CIRC-1:0] out_mask_d, out_mask_q;
  logic                out_hit_d, out_hit_q;
  logic [NUM_CIRC-1:0] cov_p3;
  logic                cfg_wr;
  logic [COORD_W-1:0]  cx_d [NUM_CIRC];
  logic [COORD_W-1:0]  cx_q [NUM_CIRC];
  logic [COORD_W-1:0]  cy_d [NUM_CIRC];
  logic [COORD_W-1:0]  cy_q [NUM_CIRC];
  logic [COORD_W-1:0]  r_d  [NUM_CIRC];
  logic [COORD_W-1:0]  r_q  [NUM_CIRC];

  for (genvar i = 0; i < NUM_CIRC; i++) begin : g_lane
    set_pe_lane #(.COORD_W(COORD_W)) u_lane (
      .clk    (clk),
      .en     (en),
      .in_x   (in_x),
      .in_y   (in_y),
      .cx     (cx_q[i]),
      .cy     (cy_q[i]),
      .r      (r_q[i]),
      .cov_p3 (cov_p3[i])
    );
  end

  always_comb begin
    en          = ~(out_valid_q & ~out_ready);
    in_ready    = en;
    cfg_busy    = vld_p1_q | vld_p2_q | vld_p3_q | out_valid_q;
    vld_p1_d    = en ? in_valid : vld_p1_q;
    vld_p2_d    = en ? vld_p1_q : vld_p2_q;
    vld_p3_d    = en ? vld_p2_q : vld_p3_q;
    out_valid_d = en ? vld_p3_q : out_valid_q;
    out_mask_d  = out_mask_q;
    out_hit_d   = out_hit_q;
    if (en && vld_p3_q) begin
      out_mask_d = cov_p3;
      out_hit_d  = hit_eval(8'(cov_p3), 8'(match_val), 8'(match_mask));
    end
    // Circles only change while the pipe is empty, so no lane sees a torn update
    cfg_wr = cfg_we & ~cfg_busy & (int'(cfg_idx) < NUM_CIRC);
    cx_d   = cx_q;
    cy_d   = cy_q;
    r_d    = r_q;
    if (cfg_wr) begin
      cx_d[cfg_idx] = cfg_cx;
      cy_d[cfg_idx] = cfg_cy;
      r_d[cfg_idx]  = cfg_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_hit_q   <= 1'b0;
      cx_q        <= '{default: '0};
      cy_q        <= '{default: '0};
      r_q         <= '{default: '0};
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_hit_q   <= out_hit_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      r_q         <= r_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_hit   = out_hit_q;

`ifdef SET_PE_HITCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] hit_cnt_d, hit_cnt_q;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d = '0;
    end else if (out_valid_q && out_ready && out_hit_q && hit_cnt_q != CNT_MAX) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_set_pe_pipe.sv
// Directed bench for set_pe_pipe with immediate-assertion checks; counter checks when SET_PE_HITCNT_EN is set.
module tb_set_pe_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_cx, cfg_cy, cfg_r;
  logic       cfg_busy;
  logic [2:0] match_mask, match_val;
  logic       in_valid, in_ready;
  logic [3:0] in_x, in_y;
  logic       out_valid, out_ready;
  logic [2:0] out_mask;
  logic       out_hit;
`ifdef SET_PE_HITCNT_EN
  logic        cnt_clr;
  logic [15:0] hit_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int bcx[3], bcy[3], br[3];

  always #5 clk = ~clk;

  set_pe_pipe #(.NUM_CIRC(3), .COORD_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_cx     (cfg_cx),
    .cfg_cy     (cfg_cy),
    .cfg_r      (cfg_r),
    .cfg_busy   (cfg_busy),
    .match_mask (match_mask),
    .match_val  (match_val),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mask   (out_mask),
`ifdef SET_PE_HITCNT_EN
    .cnt_clr    (cnt_clr),
    .hit_cnt    (hit_cnt),
`endif
    .out_hit    (out_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_mask(input int x, input int y);
    logic [2:0] m;
    m = '0;
    for (int i = 0; i < 3; i++)
      m[i] = ((x - bcx[i]) * (x - bcx[i]) + (y - bcy[i]) * (y - bcy[i])) <= br[i] * br[i];
    return m;
  endfunction

  task automatic cfg_write(input int idx, input int cx, input int cy, input int r);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_cx = 4'(cx); cfg_cy = 4'(cy); cfg_r = 4'(r);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    bcx[idx] = cx; bcy[idx] = cy; br[idx] = r;
  endtask

  task automatic run_point(input int x, input int y, output logic [2:0] m, output logic h,
                           output int lat);
    in_x = 4'(x); in_y = 4'(y); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    m = out_mask; h = out_hit;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] m;
    logic       h;
    int         lat, s, r, hits, ref_hits, px[8];
    logic [2:0] exp_m[8];
    bit         seen;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_cx = '0; cfg_cy = '0; cfg_r = '0;
    match_mask = '0; match_val = '0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
`ifdef SET_PE_HITCNT_EN
    cnt_clr = 1'b0;
`endif
    bcx = '{0, 0, 0}; bcy = '{0, 0, 0}; br = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_mask", 32'(out_mask), 0);
    check("rst_out_hit", 32'(out_hit), 0);
    check("rst_cfg_busy", 32'(cfg_busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // Three-circle coverage; inclusive boundary puts (4,3) on circle C's edge
    cfg_write(0, 3, 3, 2);
    cfg_write(1, 5, 3, 2);
    cfg_write(2, 4, 5, 2);
    run_point(4, 3, m, h, lat);
    check("t1_latency", 32'(lat), 3);
    check("t1_mask_4_3", 32'(m), 32'(3'b111));
    check("t1_hit_nomask", 32'(h), 1);
    run_point(1, 3, m, h, lat);
    check("t1_mask_1_3", 32'(m), 32'(3'b001));
    run_point(6, 3, m, h, lat);
    check("t1_mask_6_3", 32'(m), 32'(3'b010));
    match_mask = 3'b010; match_val = 3'b000;
    run_point(4, 3, m, h, lat);
    check("t1_hit_miss", 32'(h), 0);
    run_point(1, 3, m, h, lat);
    check("t1_hit_match", 32'(h), 1);
    match_mask = '0;

    // Boundary: d2 = 9, 8, 10 against r^2 = 9
    cfg_write(0, 0, 0, 3);
    run_point(3, 0, m, h, lat);
    check("t2_d2_9", 32'(m[0]), 1);
    run_point(2, 2, m, h, lat);
    check("t2_d2_8", 32'(m[0]), 1);
    run_point(3, 1, m, h, lat);
    check("t2_d2_10", 32'(m[0]), 0);

    // Widest values: d2 = 450 vs 225, and d2 = 225 exactly
    cfg_write(0, 15, 15, 15);
    run_point(0, 0, m, h, lat);
    check("t3_far_corner", 32'(m[0]), 0);
    run_point(15, 0, m, h, lat);
    check("t3_edge_225", 32'(m[0]), 1);

    // Back-to-back stream with a three-cycle downstream stall
    cfg_write(0, 3, 3, 2);
    for (int i = 0; i < 8; i++) begin
      px[i] = i;
      exp_m[i] = ref_mask(i, 3);
    end
    s = 0; r = 0;
    for (int c = 0; c < 40 && r < 8; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (s < 8) begin
        in_valid = 1'b1; in_x = 4'(px[s]); in_y = 4'd3;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 12) check("t4_in_ready", 32'(in_ready), (c >= 5 && c <= 7) ? 0 : 1);
      if (out_valid) begin
        check("t4_out_mask", 32'(out_mask), 32'(exp_m[r]));
        if (out_ready) r++;
      end
      if (in_valid && in_ready) s++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t4_sent", 32'(s), 8);
    check("t4_received", 32'(r), 8);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("t4_no_duplicate", 32'(seen), 0);

    // Config writes are ignored while a point is in flight
    cfg_write(0, 4, 4, 1);
    in_x = 4'd4; in_y = 4'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t5_busy", 32'(cfg_busy), 1);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_cx = 4'd12; cfg_cy = 4'd12; cfg_r = 4'd1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t5_inflight_mask", 32'(out_mask[0]), 1);
    @(posedge clk); #1;
    check("t5_idle", 32'(cfg_busy), 0);
    run_point(12, 12, m, h, lat);
    check("t5_write_dropped", 32'(m[0]), 0);
    run_point(4, 4, m, h, lat);
    check("t5_old_circle", 32'(m[0]), 1);
    cfg_write(0, 12, 12, 1);
    run_point(12, 12, m, h, lat);
    check("t5_write_taken", 32'(m[0]), 1);

    // Set-expression over a 9x9 grid
    cfg_write(0, 3, 3, 2);
    cfg_write(1, 5, 3, 2);
    cfg_write(2, 4, 5, 2);
    match_mask = 3'b111; match_val = 3'b101;
`ifdef SET_PE_HITCNT_EN
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
`endif
    hits = 0; ref_hits = 0;
    for (int y = 0; y < 9; y++) begin
      for (int x = 0; x < 9; x++) begin
        run_point(x, y, m, h, lat);
        if (h) hits++;
        if (ref_mask(x, y) == 3'b101) ref_hits++;
      end
    end
    check("t6_grid_hits", 32'(hits), 32'(ref_hits));
    check("t6_grid_nonzero", 32'(ref_hits > 0), 1);
`ifdef SET_PE_HITCNT_EN
    check("t6_hit_cnt", 32'(hit_cnt), 32'(ref_hits));
    in_x = 4'd3; in_y = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t6_clr_point_hit", 32'(out_hit), 1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("t6_clr_wins", 32'(hit_cnt), 0);
`endif

    // Reset mid-stream drops in-flight points and clears the circles
    in_x = 4'd3; in_y = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t7_busy_cleared", 32'(cfg_busy), 0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("t7_no_output", 32'(seen), 0);
`ifdef SET_PE_HITCNT_EN
    check("t7_cnt_cleared", 32'(hit_cnt), 0);
`endif
    run_point(0, 0, m, h, lat);
    check("t7_zero_circles_origin", 32'(m), 32'(3'b111));
    run_point(1, 0, m, h, lat);
    check("t7_zero_circles_off", 32'(m), 32'(3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
